// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared definitions for the two-master memory bus.
//   - bus command encodings (NONE / MWRITE / MREAD)
//   - default address/data widths
//   - fixed I/O addresses (LED register, switch port)
//   - arbiter state enum
//   - is_access(): true for commands that actually touch the bus
package mem_bus_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 16;

  localparam logic [1:0] NONE   = 2'b00;
  localparam logic [1:0] MWRITE = 2'b01;
  localparam logic [1:0] MREAD  = 2'b10;

  localparam logic [8:0] LED_ADDR = 9'h100;
  localparam logic [8:0] SW_ADDR  = 9'h140;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  // Command 11 is reserved and, like NONE, never wins a grant.
  function automatic logic is_access(input logic [1:0] cmd);
    return (cmd == MWRITE) || (cmd == MREAD);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: combinational 2-way round-robin picker.
//   elig[1:0] - per-master eligibility
//   last      - index granted most recently
//   pick      - chosen master index (meaningful only when valid)
//   valid     - at least one master is eligible
module rr_pick2
  import mem_bus_pkg::*;
(
  input  logic [1:0] elig,
  input  logic       last,
  output logic       pick,
  output logic       valid
);

  always_comb begin
    valid = |elig;
    // On a tie, the master that did not go last wins; otherwise the lone
    // eligible master (elig[1] alone -> 1, elig[0] alone or none -> 0).
    if (elig == 2'b11) begin
      pick = ~last;
    end else begin
      pick = elig[1];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter letting two masters share the
// single-port synchronous RAM and I/O of the memory-mapped bus.
// One access in flight at a time; writes complete in the grant cycle,
// reads spend one extra RD_WAIT cycle returning data.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   req0/cmd0/addr0/wdata0          - master 0 request
//   gnt0, rvalid0, rdata0           - master 0 grant / read return
//   req1/cmd1/addr1/wdata1          - master 1 request
//   gnt1, rvalid1, rdata1           - master 1 grant / read return
//   bus_cmd/bus_addr/bus_wdata      - to the address decode logic
//   bus_rdata                       - resolved read data from RAM or switches
module mem_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [1:0]        cmd0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [1:0]        cmd1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic [1:0]        bus_cmd,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata
);

  state_t            state_reg;
  logic              last_reg;
  logic [ADDR_W-1:0] hold_addr_reg;
  logic              hold_owner_reg;
  logic [DATA_W-1:0] rdata0_reg;
  logic [DATA_W-1:0] rdata1_reg;

  logic [1:0] req_v;
  logic [1:0] cmd_v [2];
  logic [1:0] elig;
  logic       pick;
  logic       pick_valid;
  logic [1:0] sel_cmd;
  logic [ADDR_W-1:0] sel_addr;

  assign req_v    = {req1, req0};
  assign cmd_v[0] = cmd0;
  assign cmd_v[1] = cmd1;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_elig
      assign elig[gi] = req_v[gi] && is_access(cmd_v[gi]);
    end
  endgenerate

  rr_pick2 u_pick (
    .elig  (elig),
    .last  (last_reg),
    .pick  (pick),
    .valid (pick_valid)
  );

  assign sel_cmd  = pick ? cmd1  : cmd0;
  assign sel_addr = pick ? addr1 : addr0;

  // Outputs are forced idle while reset is high so a read caught in
  // RD_WAIT by reset never signals rvalid.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    rvalid0   = 1'b0;
    rvalid1   = 1'b0;
    rdata0    = reset ? '0 : rdata0_reg;
    rdata1    = reset ? '0 : rdata1_reg;
    bus_cmd   = NONE;
    bus_addr  = '0;
    bus_wdata = '0;
    if (!reset) begin
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            gnt0      = ~pick;
            gnt1      = pick;
            bus_cmd   = sel_cmd;
            bus_addr  = sel_addr;
            bus_wdata = pick ? wdata1 : wdata0;
          end
        end
        RD_WAIT: begin
          // Keep the read address on the bus so the switch port stays
          // selected and RAM dout (captured at the grant edge) is steered out.
          bus_cmd  = MREAD;
          bus_addr = hold_addr_reg;
          if (hold_owner_reg) begin
            rvalid1 = 1'b1;
            rdata1  = bus_rdata;
          end else begin
            rvalid0 = 1'b1;
            rdata0  = bus_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_reg       <= 1'b1;
      hold_addr_reg  <= '0;
      hold_owner_reg <= 1'b0;
      rdata0_reg     <= '0;
      rdata1_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            last_reg <= pick;
            if (sel_cmd == MREAD) begin
              hold_addr_reg  <= sel_addr;
              hold_owner_reg <= pick;
              state_reg      <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (hold_owner_reg) begin
            rdata1_reg <= bus_rdata;
          end else begin
            rdata0_reg <= bus_rdata;
          end
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter with a behavioural
// bus model (synchronous RAM at 0x000-0x0FF, switch port at 0x140).
module tb_mem_arbiter;
  import mem_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [1:0]  cmd0, cmd1;
  logic [8:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata0, rdata1;
  logic [1:0]  bus_cmd;
  logic [8:0]  bus_addr;
  logic [15:0] bus_wdata, bus_rdata;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] rd_q0[$];
  logic [15:0] rd_q1[$];
  logic [15:0] exp_v;

  // Bus environment: single-port sync RAM plus a combinational switch port.
  logic [15:0] mem [0:255];
  logic [15:0] ram_dout;
  logic [15:0] sw;

  always @(posedge clk) begin
    if (bus_cmd == MWRITE && bus_addr < 9'h100) mem[bus_addr[7:0]] <= bus_wdata;
    if (bus_cmd == MREAD) ram_dout <= mem[bus_addr[7:0]];
  end
  assign bus_rdata = (bus_addr == SW_ADDR) ? sw : ram_dout;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .cmd0(cmd0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .cmd1(cmd1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .bus_cmd(bus_cmd), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req0 = 1'b1; cmd0 = MWRITE; addr0 = 9'h001; wdata0 = 16'h1111;
    @(negedge clk);
    vectors++; if (gnt0 !== 1'b0) begin miscompares++; $display("FAIL rst_gnt0_in_reset got %b exp 0", gnt0); end
    vectors++; if (bus_cmd !== NONE) begin miscompares++; $display("FAIL rst_bus_cmd_in_reset got %b exp 00", bus_cmd); end
    tick();
    reset = 1'b0; req0 = 1'b0; cmd0 = NONE;
    @(negedge clk);
    vectors++; if ({gnt0, gnt1, rvalid0, rvalid1} !== 4'b0) begin miscompares++; $display("FAIL rst_flags got %b exp 0000", {gnt0, gnt1, rvalid0, rvalid1}); end
    vectors++; if (bus_cmd !== NONE || bus_addr !== 9'h0 || bus_wdata !== 16'h0) begin miscompares++; $display("FAIL rst_bus got %h/%h/%h exp 0/0/0", bus_cmd, bus_addr, bus_wdata); end
    vectors++; if (rdata0 !== 16'h0 || rdata1 !== 16'h0) begin miscompares++; $display("FAIL rst_rdata got %h/%h exp 0/0", rdata0, rdata1); end
    $display("reset: outputs idle");
    tick();
  endtask

  task automatic test_single_write_read();
    req0 = 1'b1; cmd0 = MWRITE; addr0 = 9'h005; wdata0 = 16'hBEEF;
    @(negedge clk);
    vectors++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin miscompares++; $display("FAIL wr_gnt got %b%b exp 01", gnt1, gnt0); end
    vectors++; if (bus_cmd !== MWRITE || bus_addr !== 9'h005 || bus_wdata !== 16'hBEEF) begin miscompares++; $display("FAIL wr_bus got %h/%h/%h exp 1/005/beef", bus_cmd, bus_addr, bus_wdata); end
    $display("write m0 addr=005 data=beef gnt0=%b", gnt0);
    tick();
    cmd0 = MREAD; rd_q0.push_back(16'hBEEF);
    @(negedge clk);
    vectors++; if (gnt0 !== 1'b1 || bus_cmd !== MREAD || rvalid0 !== 1'b0) begin miscompares++; $display("FAIL rd_grant got gnt0=%b cmd=%b rvalid0=%b exp 1/10/0", gnt0, bus_cmd, rvalid0); end
    tick();
    req0 = 1'b0; cmd0 = NONE;
    @(negedge clk);
    vectors++;
    if (rvalid0 !== 1'b1) begin miscompares++; $display("FAIL rd_rvalid0 got %b exp 1", rvalid0); end
    else if (rd_q0.size() == 0) begin miscompares++; $display("FAIL rd_unexpected rvalid0 with empty scoreboard"); end
    else begin exp_v = rd_q0.pop_front(); if (rdata0 !== exp_v) begin miscompares++; $display("FAIL rd_rdata0 got %h exp %h", rdata0, exp_v); end end
    vectors++; if (bus_addr !== 9'h005 || gnt0 !== 1'b0) begin miscompares++; $display("FAIL rd_wait_bus got addr=%h gnt0=%b exp 005/0", bus_addr, gnt0); end
    $display("read m0 addr=005 rdata0=%h", rdata0);
    tick();
    @(negedge clk);
    vectors++; if (rvalid0 !== 1'b0 || rdata0 !== 16'hBEEF) begin miscompares++; $display("FAIL rd_hold got rvalid0=%b rdata0=%h exp 0/beef", rvalid0, rdata0); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic e0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0 = 1'b1; cmd0 = MWRITE; addr0 = 9'h010; wdata0 = 16'hA000;
    req1 = 1'b1; cmd1 = MWRITE; addr1 = 9'h011; wdata1 = 16'hB000;
    for (int i = 0; i < 6; i++) begin
      e0 = (i % 2 == 0);
      @(negedge clk);
      vectors++;
      if (gnt0 !== e0 || gnt1 !== !e0 || bus_addr !== (e0 ? 9'h010 : 9'h011) || bus_cmd !== MWRITE) begin
        miscompares++;
        $display("FAIL b2b_%0d got gnt=%b%b addr=%h exp gnt=%b%b addr=%h", i, gnt1, gnt0, bus_addr, !e0, e0, e0 ? 9'h010 : 9'h011);
      end
      $display("b2b write %0d gnt0=%b gnt1=%b addr=%h", i, gnt0, gnt1, bus_addr);
      tick();
    end
    req0 = 1'b0; req1 = 1'b0; cmd0 = NONE; cmd1 = NONE;
  endtask

  task automatic test_switch_read();
    sw = 16'h005A;
    req1 = 1'b1; cmd1 = MREAD; addr1 = SW_ADDR;
    rd_q1.push_back(16'h005A);
    @(negedge clk);
    vectors++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || bus_addr !== SW_ADDR) begin miscompares++; $display("FAIL sw_grant got gnt=%b%b addr=%h exp 10/140", gnt1, gnt0, bus_addr); end
    tick();
    req1 = 1'b0; cmd1 = NONE;
    @(negedge clk);
    vectors++;
    if (rvalid1 !== 1'b1 || rvalid0 !== 1'b0) begin miscompares++; $display("FAIL sw_rvalid got %b%b exp 10", rvalid1, rvalid0); end
    else if (rd_q1.size() == 0) begin miscompares++; $display("FAIL sw_unexpected rvalid1 with empty scoreboard"); end
    else begin exp_v = rd_q1.pop_front(); if (rdata1 !== exp_v) begin miscompares++; $display("FAIL sw_rdata1 got %h exp %h", rdata1, exp_v); end end
    vectors++; if (bus_addr !== SW_ADDR || bus_cmd !== MREAD) begin miscompares++; $display("FAIL sw_wait_bus got %h/%b exp 140/10", bus_addr, bus_cmd); end
    $display("read m1 addr=140 rdata1=%h", rdata1);
    tick();
  endtask

  task automatic test_read_blocks_write();
    // Master 1 seeds 0x020 so that it also goes last before the tie.
    req1 = 1'b1; cmd1 = MWRITE; addr1 = 9'h020; wdata1 = 16'h1234;
    tick();
    req1 = 1'b1; cmd1 = MWRITE; addr1 = 9'h030; wdata1 = 16'h7777;
    req0 = 1'b1; cmd0 = MREAD;  addr0 = 9'h020;
    rd_q0.push_back(16'h1234);
    @(negedge clk);
    vectors++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin miscompares++; $display("FAIL blk_tie got gnt=%b%b exp 01", gnt1, gnt0); end
    tick();
    req0 = 1'b0; cmd0 = NONE;
    @(negedge clk);
    vectors++; if (gnt1 !== 1'b0) begin miscompares++; $display("FAIL blk_gnt1_in_wait got %b exp 0", gnt1); end
    vectors++;
    if (rvalid0 !== 1'b1) begin miscompares++; $display("FAIL blk_rvalid0 got %b exp 1", rvalid0); end
    else if (rd_q0.size() == 0) begin miscompares++; $display("FAIL blk_unexpected rvalid0 with empty scoreboard"); end
    else begin exp_v = rd_q0.pop_front(); if (rdata0 !== exp_v) begin miscompares++; $display("FAIL blk_rdata0 got %h exp %h", rdata0, exp_v); end end
    $display("read m0 addr=020 rdata0=%h gnt1=%b", rdata0, gnt1);
    tick();
    @(negedge clk);
    vectors++; if (gnt1 !== 1'b1 || bus_cmd !== MWRITE || bus_addr !== 9'h030 || bus_wdata !== 16'h7777) begin miscompares++; $display("FAIL blk_late_gnt1 got gnt1=%b %b/%h/%h exp 1 01/030/7777", gnt1, bus_cmd, bus_addr, bus_wdata); end
    $display("write m1 addr=030 gnt1=%b", gnt1);
    tick();
    req1 = 1'b0; cmd1 = NONE;
  endtask

  task automatic test_reset_in_rd_wait();
    req0 = 1'b1; cmd0 = MREAD; addr0 = 9'h030;
    @(negedge clk);
    vectors++; if (gnt0 !== 1'b1) begin miscompares++; $display("FAIL rrw_grant got %b exp 1", gnt0); end
    tick();
    req0 = 1'b0; cmd0 = NONE; reset = 1'b1;
    @(negedge clk);
    vectors++; if (rvalid0 !== 1'b0) begin miscompares++; $display("FAIL rrw_rvalid0 got %b exp 0", rvalid0); end
    tick();
    reset = 1'b0;
    @(negedge clk);
    vectors++; if (bus_cmd !== NONE || rvalid0 !== 1'b0 || rdata0 !== 16'h0) begin miscompares++; $display("FAIL rrw_after got cmd=%b rvalid0=%b rdata0=%h exp 00/0/0000", bus_cmd, rvalid0, rdata0); end
    tick();
    req0 = 1'b1; cmd0 = MWRITE; addr0 = 9'h040; wdata0 = 16'h0001;
    req1 = 1'b1; cmd1 = MWRITE; addr1 = LED_ADDR; wdata1 = 16'h0002;
    @(negedge clk);
    vectors++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin miscompares++; $display("FAIL rrw_tie got gnt=%b%b exp 01", gnt1, gnt0); end
    $display("reset in rd_wait: tie gnt0=%b gnt1=%b", gnt0, gnt1);
    tick();
    req0 = 1'b0; cmd0 = NONE;
    @(negedge clk);
    vectors++; if (gnt1 !== 1'b1 || bus_addr !== LED_ADDR || bus_cmd !== MWRITE) begin miscompares++; $display("FAIL led_write got gnt1=%b addr=%h cmd=%b exp 1/100/01", gnt1, bus_addr, bus_cmd); end
    tick();
    req1 = 1'b0; cmd1 = NONE;
  endtask

  task automatic test_illegal_cmd();
    req0 = 1'b1; cmd0 = 2'b11; addr0 = 9'h003;
    req1 = 1'b1; cmd1 = NONE;  addr1 = 9'h004;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || bus_cmd !== NONE) begin
        miscompares++;
        $display("FAIL illegal_%0d got gnt=%b%b cmd=%b exp 00/00", i, gnt1, gnt0, bus_cmd);
      end
      $display("illegal cmd cycle %0d gnt0=%b gnt1=%b bus_cmd=%b", i, gnt0, gnt1, bus_cmd);
      tick();
    end
    req0 = 1'b0; req1 = 1'b0; cmd0 = NONE;
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b0; cmd0 = NONE; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; cmd1 = NONE; addr1 = '0; wdata1 = '0;
    sw = 16'h0000;
    tick();
    test_reset();
    test_single_write_read();
    test_back_to_back();
    test_switch_read();
    test_read_blocks_write();
    test_reset_in_rd_wait();
    test_illegal_cmd();
    vectors++;
    if (rd_q0.size() != 0 || rd_q1.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover got %0d/%0d exp 0/0", rd_q0.size(), rd_q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
